fixed_huffman_block_controller: RTL and testbench

//   Sequences the fixed-Huffman literal path of the compressor. Accepts a literal byte stream
//   and wraps it into DEFLATE BTYPE=01 blocks: block header, literals via Literal_Encoder,
//   end-of-block code. Emits one code word per handshake to the downstream bit packer.

---
 rtl/fixed_huffman_block_controller_pkg.sv | 37 +++
 rtl/fixed_huffman_block_controller_if.sv | 34 +++
 rtl/fixed_huffman_block_controller_lit_enc.sv | 34 +++
 rtl/fixed_huffman_block_controller.sv | 148 ++++++++++++++
 tb/tb_fixed_huffman_block_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_huffman_block_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_huffman_block_controller_pkg
// Description : Shared types and DEFLATE fixed-Huffman constants.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_huffman_block_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LIT  = 3'd2,
    S_EOB  = 3'd3,
    S_FHDR = 3'd4,
    S_FEOB = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam int CODE_W  = 18;
  localparam int LEN_W   = 5;
  localparam int TOTAL_W = 32;

  localparam logic [1:0]       BTYPE_FIXED = 2'b01;
  localparam logic [6:0]       EOB_CODE    = 7'd0;
  localparam logic [LEN_W-1:0] EOB_LEN     = 5'd7;
  localparam logic [LEN_W-1:0] HDR_LEN     = 5'd3;
  localparam logic [8:0]       LIT_SPLIT   = 9'd144;
  localparam logic [8:0]       LIT_OFS_LO  = 9'd48;
  localparam logic [8:0]       LIT_OFS_HI  = 9'd256;

  // Header is sent LSB first, so BFINAL sits in bit 0 with BTYPE above it.
  function automatic logic [2:0] hdr_field(input logic bfinal);
    return {BTYPE_FIXED, bfinal};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_huffman_block_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fixed_huffman_block_controller_if
// Description : Literal input and code-word output channels of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface fixed_huffman_block_controller_if;

  logic        lit_valid;
  logic [7:0]  lit_data;
  logic        lit_last;
  logic        lit_ready;
  logic        code_valid;
  logic [17:0] code_bits;
  logic [4:0]  code_len;
  logic        code_msb_1st;
  logic        code_ready;
  logic        stream_done;
  logic [31:0] total_bits;

  modport master (
    input  lit_valid, lit_data, lit_last, code_ready,
    output lit_ready, code_valid, code_bits, code_len, code_msb_1st,
           stream_done, total_bits
  );

  modport slave (
    output lit_valid, lit_data, lit_last, code_ready,
    input  lit_ready, code_valid, code_bits, code_len, code_msb_1st,
           stream_done, total_bits
  );

endinterface
`default_nettype wire

// File: rtl/fixed_huffman_block_controller_lit_enc.sv
`default_nettype none
// ============================================================================
// Module      : fixed_huffman_block_controller_lit_enc
// Description : Literal_Encoder - fixed-Huffman code for literals 0..255.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_huffman_block_controller_lit_enc
  import fixed_huffman_block_controller_pkg::*;
(
  input  logic             i_en,
  input  logic [7:0]       i_lit,
  output logic [8:0]       o_code,
  output logic [LEN_W-1:0] o_len
);

  logic [8:0] w_lit;

  always_comb begin
    w_lit  = {1'b0, i_lit};
    o_code = '0;
    o_len  = '0;
    if (i_en) begin
      if (w_lit < LIT_SPLIT) begin
        o_code = w_lit + LIT_OFS_LO;
        o_len  = 5'd8;
      end else begin
        o_code = w_lit + LIT_OFS_HI;
        o_len  = 5'd9;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fixed_huffman_block_controller.sv
`default_nettype none
// ============================================================================
// Module      : fixed_huffman_block_controller
// Description : Wraps a literal stream into fixed-Huffman DEFLATE blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_huffman_block_controller
  import fixed_huffman_block_controller_pkg::*;
#(
  parameter int MAX_BLOCK_LITERALS = 16384,
  parameter int CNT_W              = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  fixed_huffman_block_controller_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BLOCK_LITERALS - 1);

  state_t              r_state;
  logic                r_code_valid;
  logic [CODE_W-1:0]   r_code_bits;
  logic [LEN_W-1:0]    r_code_len;
  logic                r_code_msb_1st;
  logic                r_stream_done;
  logic [TOTAL_W-1:0]  r_total_bits;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_last;

  logic                w_free;
  logic                w_hs;
  logic                w_lit_acc;
  logic [8:0]          w_enc_code;
  logic [LEN_W-1:0]    w_enc_len;

  assign w_free    = !r_code_valid || bus.code_ready;
  assign w_hs      = r_code_valid && bus.code_ready;
  assign w_lit_acc = (r_state == S_LIT) && bus.lit_valid && w_free;

  fixed_huffman_block_controller_lit_enc u_lit_enc (
    .i_en   (w_lit_acc),
    .i_lit  (bus.lit_data),
    .o_code (w_enc_code),
    .o_len  (w_enc_len)
  );

  // A load into the output register overrides the handshake-driven clear below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_code_valid   <= 1'b0;
      r_code_bits    <= '0;
      r_code_len     <= '0;
      r_code_msb_1st <= 1'b0;
      r_stream_done  <= 1'b0;
      r_cnt          <= '0;
      r_last         <= 1'b0;
    end else begin
      r_stream_done <= 1'b0;
      if (w_hs) begin
        r_code_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.lit_valid) begin
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_free) begin
            r_code_valid   <= 1'b1;
            r_code_bits    <= CODE_W'(hdr_field(1'b0));
            r_code_len     <= HDR_LEN;
            r_code_msb_1st <= 1'b0;
            r_cnt          <= '0;
            r_state        <= S_LIT;
          end
        end
        S_LIT: begin
          if (w_lit_acc) begin
            r_code_valid   <= 1'b1;
            r_code_bits    <= CODE_W'(w_enc_code);
            r_code_len     <= w_enc_len;
            r_code_msb_1st <= 1'b1;
            r_cnt          <= r_cnt + CNT_W'(1);
            r_last         <= bus.lit_last;
            if (bus.lit_last || (r_cnt == CNT_LIMIT)) begin
              r_state <= S_EOB;
            end
          end
        end
        S_EOB: begin
          if (w_free) begin
            r_code_valid   <= 1'b1;
            r_code_bits    <= CODE_W'(EOB_CODE);
            r_code_len     <= EOB_LEN;
            r_code_msb_1st <= 1'b1;
            r_state        <= r_last ? S_FHDR : S_HDR;
          end
        end
        S_FHDR: begin
          if (w_free) begin
            r_code_valid   <= 1'b1;
            r_code_bits    <= CODE_W'(hdr_field(1'b1));
            r_code_len     <= HDR_LEN;
            r_code_msb_1st <= 1'b0;
            r_state        <= S_FEOB;
          end
        end
        S_FEOB: begin
          if (w_free) begin
            r_code_valid   <= 1'b1;
            r_code_bits    <= CODE_W'(EOB_CODE);
            r_code_len     <= EOB_LEN;
            r_code_msb_1st <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_hs) begin
            r_stream_done <= 1'b1;
            r_last        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total_bits <= '0;
    end else if (w_hs) begin
      r_total_bits <= r_total_bits + TOTAL_W'(r_code_len);
    end
  end

  assign bus.lit_ready    = (r_state == S_LIT) && w_free;
  assign bus.code_valid   = r_code_valid;
  assign bus.code_bits    = r_code_bits;
  assign bus.code_len     = r_code_len;
  assign bus.code_msb_1st = r_code_msb_1st;
  assign bus.stream_done  = r_stream_done;
  assign bus.total_bits   = r_total_bits;

endmodule
`default_nettype wire

// File: tb/tb_fixed_huffman_block_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_huffman_block_controller
// Description : Directed bench for the fixed-Huffman block controller (MAX=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_huffman_block_controller;

  logic clk;
  logic rst_n;

  fixed_huffman_block_controller_if bus ();

  fixed_huffman_block_controller #(
    .MAX_BLOCK_LITERALS (4),
    .CNT_W              (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] q [$];
  int          done_cnt = 0;
  logic [7:0]  stim  [0:15];
  int          stim_n;
  logic [23:0] exp_w [0:15];
  int          exp_n;

  // Word layout: {msb_1st, len[4:0], bits[17:0]}
  always @(negedge clk) begin
    if (bus.code_valid && bus.code_ready)
      q.push_back({bus.code_msb_1st, bus.code_len, bus.code_bits});
    if (bus.stream_done)
      done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mkw(input logic msb, input logic [4:0] len, input logic [17:0] bits);
    return {msb, len, bits};
  endfunction

  task automatic clr();
    stim_n = 0;
    exp_n  = 0;
  endtask

  task automatic lit(input logic [7:0] b);
    stim[stim_n] = b;
    stim_n++;
  endtask

  task automatic ew(input logic msb, input logic [4:0] len, input logic [17:0] bits);
    exp_w[exp_n] = mkw(msb, len, bits);
    exp_n++;
  endtask

  task automatic e_hdr();
    ew(1'b0, 5'd3, 18'h2);
  endtask

  task automatic e_eob();
    ew(1'b1, 5'd7, 18'h0);
  endtask

  task automatic e_tail();
    ew(1'b1, 5'd7, 18'h0);
    ew(1'b0, 5'd3, 18'h3);
    ew(1'b1, 5'd7, 18'h0);
  endtask

  task automatic run_stream();
    int t;
    for (int i = 0; i < stim_n; i++) begin
      bus.lit_valid = 1'b1;
      bus.lit_data  = stim[i];
      bus.lit_last  = (i == stim_n - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.lit_ready && t < 200);
      if (!bus.lit_ready) begin
        check("lit_accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.lit_valid = 1'b0;
    bus.lit_last  = 1'b0;
    t = 0;
    while (t < 200 && bus.stream_done !== 1'b1) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input int qb, input int d0, input logic [31:0] tot);
    check({tag, "_nwords"}, 32'(q.size() - qb), 32'(exp_n));
    for (int i = 0; i < exp_n && (qb + i) < q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), {8'h0, q[qb + i]}, {8'h0, exp_w[i]});
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_total_bits"}, bus.total_bits, tot);
  endtask

  task automatic do_stream(input string tag, input logic [31:0] tot);
    int qb;
    int d0;
    qb = q.size();
    d0 = done_cnt;
    run_stream();
    check_stream(tag, qb, d0, tot);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_code_valid"}, {31'b0, bus.code_valid}, 32'd0);
    check({tag, "_code_bits"}, {14'b0, bus.code_bits}, 32'd0);
    check({tag, "_code_len"}, {27'b0, bus.code_len}, 32'd0);
    check({tag, "_msb_1st"}, {31'b0, bus.code_msb_1st}, 32'd0);
    check({tag, "_stream_done"}, {31'b0, bus.stream_done}, 32'd0);
    check({tag, "_total_bits"}, bus.total_bits, 32'd0);
    check({tag, "_lit_ready"}, {31'b0, bus.lit_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] held;
    int qb;
    int d0;
    rst_n          = 1'b0;
    bus.lit_valid  = 1'b0;
    bus.lit_data   = 8'h00;
    bus.lit_last   = 1'b0;
    bus.code_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single literal closing the stream.
    clr(); lit(8'h41);
    e_hdr(); ew(1'b1, 5'd8, 18'h071); e_tail();
    do_stream("single", 32'd28);

    // Encoder split around 144.
    clr(); lit(8'hC8); lit(8'h8F); lit(8'h90);
    e_hdr(); ew(1'b1, 5'd9, 18'h1C8); ew(1'b1, 5'd8, 18'h0BF); ew(1'b1, 5'd9, 18'h190); e_tail();
    do_stream("split", 32'd74);

    // Six literals across a 4-literal block limit.
    clr(); lit(8'h00); lit(8'h01); lit(8'h02); lit(8'h03); lit(8'h04); lit(8'hFF);
    e_hdr(); ew(1'b1, 5'd8, 18'h030); ew(1'b1, 5'd8, 18'h031); ew(1'b1, 5'd8, 18'h032);
    ew(1'b1, 5'd8, 18'h033); e_eob();
    e_hdr(); ew(1'b1, 5'd8, 18'h034); ew(1'b1, 5'd9, 18'h1FF); e_tail();
    do_stream("limit6", 32'd153);

    // Last literal coincides with the block limit.
    clr(); lit(8'h10); lit(8'h20); lit(8'h30); lit(8'h40);
    e_hdr(); ew(1'b1, 5'd8, 18'h040); ew(1'b1, 5'd8, 18'h050); ew(1'b1, 5'd8, 18'h060);
    ew(1'b1, 5'd8, 18'h070); e_tail();
    do_stream("limit4", 32'd205);

    // Backpressure while the second literal word is held.
    clr(); lit(8'h61); lit(8'h62); lit(8'h63);
    e_hdr(); ew(1'b1, 5'd8, 18'h091); ew(1'b1, 5'd8, 18'h092); ew(1'b1, 5'd8, 18'h093); e_tail();
    qb = q.size();
    d0 = done_cnt;
    fork
      run_stream();
      begin
        int t;
        t = 0;
        while (q.size() < qb + 2 && t < 200) begin
          @(posedge clk);
          t++;
        end
        #1 bus.code_ready = 1'b0;
        @(negedge clk);
        held = {bus.code_msb_1st, bus.code_len, bus.code_bits};
        check("bp_valid", {31'b0, bus.code_valid}, 32'd1);
        check("bp_held_word", {8'h0, held}, {8'h0, mkw(1'b1, 5'd8, 18'h092)});
        repeat (5) begin
          @(negedge clk);
          check("bp_stable", {8'h0, bus.code_msb_1st, bus.code_len, bus.code_bits}, {8'h0, held});
          check("bp_lit_ready", {31'b0, bus.lit_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus.code_ready = 1'b1;
      end
    join
    check_stream("bp", qb, d0, 32'd249);

    // Reset while a literal-block word is stalled in the output register.
    bus.code_ready = 1'b0;
    bus.lit_valid  = 1'b1;
    bus.lit_data   = 8'h55;
    bus.lit_last   = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_pre_valid", {31'b0, bus.code_valid}, 32'd1);
    check("rst_pre_bits", {14'b0, bus.code_bits}, 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    bus.lit_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n          = 1'b1;
    bus.code_ready = 1'b1;
    repeat (2) @(negedge clk);

    clr(); lit(8'h41);
    e_hdr(); ew(1'b1, 5'd8, 18'h071); e_tail();
    do_stream("after_reset", 32'd28);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
